adaboost_weighted_vote: RTL and testbench

Downstream consumer of the AdaBoost bagging weight memory. On `start` it sweeps weight addresses 0..N_LEARNERS-1 through the memory's registered read port. For each address it adds or subtracts the returned signed weight according to that weak learner's latched vote, then reports the signed ensemble score and the final class. It replaces ad-hoc top-level read sequencing with a single handshaked stage.

---
 rtl/adaboost_weighted_vote_pkg.sv | 19 +
 rtl/adaboost_weighted_vote_if.sv | 16 +
 rtl/ada_score_acc.sv | 71 +++++++
 rtl/adaboost_weighted_vote.sv | 100 ++++++++++
 tb/tb_adaboost_weighted_vote.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adaboost_weighted_vote_pkg.sv
// Shared defaults, FSM state encoding and vote encoding for the AdaBoost weighted vote stage.
package ada_pkg;

   localparam int unsigned N_LEARNERS = 30;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned W_WIDTH    = 9;
   localparam int unsigned ACC_WIDTH  = 15;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StLast,
      StDone
   } state_e;

   localparam logic VOTE_POS = 1'b1;
   localparam logic VOTE_NEG = 1'b0;

endpackage

// File: rtl/adaboost_weighted_vote_if.sv
// Weight-memory read port: the vote stage is master (address/read), the memory is slave (data).
interface adaboost_weighted_vote_if
   import ada_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ada_pkg::ADDR_WIDTH,
   parameter int unsigned W_WIDTH    = ada_pkg::W_WIDTH
);

   logic [ADDR_WIDTH-1:0]     mem_address;
   logic                      mem_read;
   logic signed [W_WIDTH-1:0] mem_dataout;

   modport master (output mem_address, output mem_read, input mem_dataout);
   modport slave  (input mem_address, input mem_read, output mem_dataout);

endinterface

// File: rtl/ada_score_acc.sv
// Clear/enable/sign-select score accumulator; ADA_SCORE_SAT_EN selects saturation over wrap.
module ada_score_acc
   import ada_pkg::*;
#(
   parameter int unsigned W_WIDTH   = ada_pkg::W_WIDTH,
   parameter int unsigned ACC_WIDTH = ada_pkg::ACC_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        en,
   input  logic                        sign,
   input  logic signed [W_WIDTH-1:0]   weight,
   output logic signed [ACC_WIDTH-1:0] acc,
   output logic signed [ACC_WIDTH-1:0] acc_next
);

   localparam int unsigned MaxW = (ACC_WIDTH > W_WIDTH) ? ACC_WIDTH : W_WIDTH;
`ifdef ADA_SCORE_SAT_EN
   // Two guard bits keep the true sum exact so the clip decision is never fooled by a wrap.
   localparam int unsigned SumW = MaxW + 2;
   localparam logic signed [SumW-1:0] SatMax = SumW'((64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1);
   localparam logic signed [SumW-1:0] SatMin = ~SatMax;
`else
   localparam int unsigned SumW = MaxW;
`endif

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [SumW-1:0]      acc_ext;
   logic signed [SumW-1:0]      term;
   logic signed [SumW-1:0]      sum;

   always_comb begin
      acc_ext = SumW'(acc_q);
      term    = SumW'(weight);
      if (sign == VOTE_NEG) begin
         term = -term;
      end
      sum = acc_ext + term;
   end

   always_comb begin
      acc_next = acc_q;
      if (clear) begin
         acc_next = '0;
      end else if (en) begin
`ifdef ADA_SCORE_SAT_EN
         if (sum > SatMax) begin
            acc_next = SatMax[ACC_WIDTH-1:0];
         end else if (sum < SatMin) begin
            acc_next = SatMin[ACC_WIDTH-1:0];
         end else begin
            acc_next = sum[ACC_WIDTH-1:0];
         end
`else
         acc_next = sum[ACC_WIDTH-1:0];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_next;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/adaboost_weighted_vote.sv
// Sweeps the weight memory once per start and reports the signed ensemble score and class.
// Build option: ADA_SCORE_SAT_EN (saturating score, implemented in ada_score_acc).
module adaboost_weighted_vote
   import ada_pkg::*;
#(
   parameter int unsigned N_LEARNERS = ada_pkg::N_LEARNERS,
   parameter int unsigned ADDR_WIDTH = ada_pkg::ADDR_WIDTH,
   parameter int unsigned W_WIDTH    = ada_pkg::W_WIDTH,
   parameter int unsigned ACC_WIDTH  = ada_pkg::ACC_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_LEARNERS-1:0]       votes,
   adaboost_weighted_vote_if.master    mem,
   output logic                        busy,
   output logic                        done,
   output logic signed [ACC_WIDTH-1:0] score,
   output logic                        class_out
);

   state_e                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       idx_q;
   logic [ADDR_WIDTH-1:0]       idx_dly_q;
   logic                        acc_en_q;
   logic [N_LEARNERS-1:0]       vote_q;
   logic                        class_q;
   logic                        accept;
   logic                        last_idx;
   logic signed [ACC_WIDTH-1:0] acc_next;

   assign accept   = (state_q == StIdle) && start;
   assign last_idx = (idx_q == ADDR_WIDTH'(N_LEARNERS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: if (last_idx) state_d = StLast;
         StLast:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem.mem_read    = (state_q == StFetch);
      mem.mem_address = (state_q == StFetch) ? idx_q : '0;
      busy            = (state_q != StIdle);
      done            = (state_q == StDone);
   end

   // The weight returns one cycle after its address, so the vote index trails by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         idx_dly_q <= '0;
         acc_en_q  <= 1'b0;
         vote_q    <= '0;
         class_q   <= 1'b0;
      end else begin
         if (accept) begin
            vote_q <= votes;
            idx_q  <= '0;
         end else if (state_q == StFetch) begin
            idx_q <= idx_q + 1'b1;
         end
         idx_dly_q <= idx_q;
         acc_en_q  <= (state_q == StFetch);
         if (state_q == StLast) begin
            class_q <= ~acc_next[ACC_WIDTH-1];
         end
      end
   end

   ada_score_acc #(
      .W_WIDTH   (W_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .en       (acc_en_q),
      .sign     (vote_q[idx_dly_q]),
      .weight   (mem.mem_dataout),
      .acc      (score),
      .acc_next (acc_next)
   );

   assign class_out = class_q;

endmodule

// File: tb/tb_adaboost_weighted_vote.sv
// Randomized self-checking bench: default-width DUT plus an ACC_WIDTH=8 DUT sharing one weight table.
module tb_adaboost_weighted_vote;

   localparam int NL = 30;
`ifdef ADA_SCORE_SAT_EN
   localparam bit SAT    = 1'b1;
   localparam int EXP_S5 = 127;
`else
   localparam bit SAT    = 1'b0;
   localparam int EXP_S5 = -30;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [NL-1:0]        votes = '0;
   logic                 busy, done, class_out;
   logic signed [14:0]   score;
   logic                 busy_s, done_s, class_s;
   logic signed [7:0]    score_s;

   logic signed [8:0]    weights [NL];

   int n_checks = 0;
   int n_err    = 0;

   adaboost_weighted_vote_if mem_if ();
   adaboost_weighted_vote_if mem_if_s ();

   adaboost_weighted_vote dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .votes     (votes),
      .mem       (mem_if),
      .busy      (busy),
      .done      (done),
      .score     (score),
      .class_out (class_out)
   );

   adaboost_weighted_vote #(.ACC_WIDTH(8)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .votes     (votes),
      .mem       (mem_if_s),
      .busy      (busy_s),
      .done      (done_s),
      .score     (score_s),
      .class_out (class_s)
   );

   always #5 clk = ~clk;

   // Registered-read weight memories.
   always @(posedge clk) begin
      if (mem_if.mem_read) mem_if.mem_dataout <= weights[mem_if.mem_address];
      if (mem_if_s.mem_read) mem_if_s.mem_dataout <= weights[mem_if_s.mem_address];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_score(input logic [NL-1:0] v, input int accw, input bit sat);
      int a  = 0;
      int hi = (1 << (accw - 1)) - 1;
      int lo = -(1 << (accw - 1));
      for (int k = 0; k < NL; k++) begin
         a = v[k] ? a + int'(weights[k]) : a - int'(weights[k]);
         if (sat) begin
            if (a > hi) a = hi;
            if (a < lo) a = lo;
         end
      end
      if (!sat) begin
         a = a & ((1 << accw) - 1);
         if (a > hi) a = a - (1 << accw);
      end
      return a;
   endfunction

   // Reference: cyc counts cycles since the accepting edge (0 = idle, 32 = done cycle).
   int cyc = 0;
   bit model_on = 1'b0;
   int fin_main, fin_s;
   int hold_main = 0, hold_s = 0;
   int hold_class = 0, hold_class_s = 0;

   always @(posedge clk) begin
      if (rst) begin
         cyc = 0;
         hold_main = 0;
         hold_s = 0;
         hold_class = 0;
         hold_class_s = 0;
         model_on = 1'b1;
      end else if (cyc == 0) begin
         if (start) begin
            cyc = 1;
            fin_main = model_score(votes, 15, SAT);
            fin_s    = model_score(votes, 8, SAT);
         end
      end else if (cyc == NL + 2) begin
         cyc = 0;
      end else begin
         cyc++;
         if (cyc == NL + 2) begin
            hold_main    = fin_main;
            hold_s       = fin_s;
            hold_class   = (fin_main >= 0) ? 1 : 0;
            hold_class_s = (fin_s >= 0) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("busy", busy, int'(cyc != 0));
         chk("done", done, int'(cyc == NL + 2));
         chk("mem_read", mem_if.mem_read, int'(cyc >= 1 && cyc <= NL));
         chk("mem_address", int'(mem_if.mem_address), (cyc >= 1 && cyc <= NL) ? cyc - 1 : 0);
         chk("busy_s", busy_s, int'(cyc != 0));
         chk("done_s", done_s, int'(cyc == NL + 2));
         chk("mem_read_s", mem_if_s.mem_read, int'(cyc >= 1 && cyc <= NL));
         chk("class_out", class_out, hold_class);
         chk("class_out_s", class_s, hold_class_s);
         if (cyc == 0 || cyc == NL + 2) begin
            chk("score", int'(score), hold_main);
            chk("score_s", int'(score_s), hold_s);
         end else if (cyc == 1) begin
            chk("score_clear", int'(score), 0);
            chk("score_clear_s", int'(score_s), 0);
         end
      end
   end

   bit chained = 1'b0;

   // One evaluation; inj>0 pulses start with v2 at that FETCH cycle; chain re-requests in DONE.
   task automatic run(input logic [NL-1:0] v, input int inj, input logic [NL-1:0] v2,
                      input bit chain);
      int first = 0;
      int ndone = 0;
      int nrd   = 0;
      if (chained) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      votes = v;
      @(posedge clk);
      #1;
      start   = 1'b0;
      chained = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == inj) begin
            start = 1'b1;
            votes = v2;
         end
         if (inj > 0 && i == inj + 1) start = 1'b0;
         if (mem_if.mem_read) nrd++;
         if (done) begin
            ndone++;
            if (first == 0) first = i;
            if (chain) begin
               start   = 1'b1;
               votes   = ~v;
               chained = 1'b1;
               break;
            end
         end
      end
      chk("done_cycle", first, NL + 2);
      chk("done_pulses", ndone, 1);
      chk("read_cycles", nrd, NL);
   endtask

   task automatic set_weights(input int w);
      for (int k = 0; k < NL; k++) weights[k] = 9'(w);
   endtask

   initial begin
      set_weights(0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_read", mem_if.mem_read, 0);
      chk("rst_addr", int'(mem_if.mem_address), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_class", class_out, 0);

      set_weights(1);
      run('1, 0, '0, 1'b0);
      chk("s1_score", int'(score), 30);
      chk("s1_class", class_out, 1);
      chk("s1_model", hold_main, 30);

      set_weights(10);
      run(30'h3FF, 0, '0, 1'b0);
      chk("s2_score", int'(score), -100);
      chk("s2_class", class_out, 0);
      chk("s2_model", hold_main, -100);

      set_weights(5);
      run(30'h2AAA_AAAA, 0, '0, 1'b0);
      chk("s3_score", int'(score), 0);
      chk("s3_class", class_out, 1);

      set_weights(255);
      run('1, 0, '0, 1'b0);
      chk("s4_score", int'(score), 7650);
      chk("s4_score_s", int'(score_s), EXP_S5);
      chk("s4_model_s", hold_s, EXP_S5);

      // Reset during the 10th FETCH cycle.
      start = 1'b1;
      votes = 30'(($urandom()));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_read", mem_if.mem_read, 0);
      chk("mid_rst_addr", int'(mem_if.mem_address), 0);
      chk("mid_rst_done", done, 0);
      set_weights(3);
      run('0, 0, '0, 1'b0);
      chk("s5_score", int'(score), -90);

      // Restart attempt in FETCH cycle 5 must be ignored.
      set_weights(7);
      run(30'h0000_00FF, 5, '1, 1'b0);
      chk("s6_score", int'(score), 7 * 8 - 7 * 22);
      chk("s6_class", class_out, 0);

      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < NL; k++) weights[k] = 9'($urandom_range(0, 511));
         run(30'($urandom()), (r % 4 == 2) ? int'($urandom_range(1, 28)) : 0,
             30'($urandom()), (r % 3 == 1) && (r < 15));
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
